// File: rtl/bird_collision_if.sv
// Bus between the bird/pipe stages and the collision/score stage.
// master drives bird position, pipe column and strobes; slave returns game status and score.
interface bird_collision_if;
    localparam int unsigned ROW_W   = 8;
    localparam int unsigned DIGIT_W = 4;

    logic [ROW_W-1:0]   position;
    logic [ROW_W-1:0]   pipe_col;
    logic               pipe_shift;
    logic               start;
    logic               running;
    logic               freeze;
    logic               hit;
    logic               game_over;
    logic [DIGIT_W-1:0] score_ones;
    logic [DIGIT_W-1:0] score_tens;

    modport master (
        output position, pipe_col, pipe_shift, start,
        input  running, freeze, hit, game_over, score_ones, score_tens
    );

    modport slave (
        input  position, pipe_col, pipe_shift, start,
        output running, freeze, hit, game_over, score_ones, score_tens
    );
endinterface

// File: rtl/bird_collision.sv
// Game-state stage: detects crashes, counts cleared pipes as a saturating
// two-digit BCD score and freezes the bird/pipe stages outside of play.
module bird_collision #(
    parameter int unsigned MAX_TENS = 9
) (
    input  logic              clk,
    input  logic              reset,
    bird_collision_if.slave   bus
);
    localparam int unsigned ROW_W   = 8;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIGIT_W-1:0] ones;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones_next;
    logic [DIGIT_W-1:0] tens_next;
    logic               hit_next;
    logic               running;
    logic               freeze;
    logic               hit;
    logic               game_over;

    logic               crash_c;
    logic               cleared_c;
    logic               at_max_c;

    // A dropped bird (no row lit) counts as a crash, as does any overlap.
    always_comb begin
        crash_c   = ((bus.position & bus.pipe_col) != ROW_W'(0)) ||
                    (bus.position == ROW_W'(0));
        cleared_c = bus.pipe_shift && (bus.pipe_col != ROW_W'(0));
        at_max_c  = (tens == DIGIT_W'(MAX_TENS)) && (ones == DIGIT_W'(9));
    end

    // Next-state and score update.
    always_comb begin
        state_next = state;
        ones_next  = ones;
        tens_next  = tens;
        hit_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = PLAY;
                    ones_next  = '0;
                    tens_next  = '0;
                end
            end

            PLAY: begin
                if (crash_c) begin
                    state_next = OVER;
                    hit_next   = 1'b1;
                end else if (cleared_c && !at_max_c) begin
                    if (ones == DIGIT_W'(9)) begin
                        ones_next = '0;
                        tens_next = tens + DIGIT_W'(1);
                    end else begin
                        ones_next = ones + DIGIT_W'(1);
                    end
                end
            end

            OVER: begin
                if (bus.start) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, score and status flags are all flopped; status tracks next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ones      <= '0;
            tens      <= '0;
            running   <= 1'b0;
            freeze    <= 1'b1;
            hit       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            ones      <= ones_next;
            tens      <= tens_next;
            running   <= (state_next == PLAY);
            freeze    <= (state_next != PLAY);
            hit       <= hit_next;
            game_over <= (state_next == OVER);
        end
    end

    assign bus.running    = running;
    assign bus.freeze     = freeze;
    assign bus.hit        = hit;
    assign bus.game_over  = game_over;
    assign bus.score_ones = ones;
    assign bus.score_tens = tens;
endmodule

// File: tb/tb_bird_collision.sv
// Self-checking bench for bird_collision: directed scenarios plus a random
// run, all compared against a score/state model kept as plain integers.
module tb_bird_collision;
    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    // Model: 0 = idle, 1 = play, 2 = over; score held as an integer 0..99.
    int   m_state;
    int   m_score;
    bit   m_hit;

    bird_collision_if bus ();

    bird_collision #(.MAX_TENS(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [7:0] pos, input logic [7:0] pc,
                         input logic sh, input logic st, input logic rst);
        bit crash;
        reset          = rst;
        bus.position   = pos;
        bus.pipe_col   = pc;
        bus.pipe_shift = sh;
        bus.start      = st;
        crash = ((pos & pc) != 8'h00) || (pos == 8'h00);
        if (rst) begin
            m_state = 0; m_score = 0; m_hit = 0;
        end else begin
            m_hit = 0;
            case (m_state)
                0: if (st) begin m_state = 1; m_score = 0; end
                1: if (crash) begin
                       m_state = 2; m_hit = 1;
                   end else if (sh && pc != 8'h00 && m_score < 99) begin
                       m_score = m_score + 1;
                   end
                default: if (st) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.freeze !== 1'b1 || bus.running !== 1'b0 || bus.game_over !== 1'b0 || bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags run=%b frz=%b over=%b hit=%b expected run=0 frz=1 over=0 hit=0",
                     bus.running, bus.freeze, bus.game_over, bus.hit);
        end
        vectors++;
        if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
            errors++;
            $display("FAIL reset_score got %h%h expected 00", bus.score_tens, bus.score_ones);
        end
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.running !== 1'b1 || bus.freeze !== 1'b0) begin
            errors++;
            $display("FAIL start_play run=%b frz=%b expected run=1 frz=0", bus.running, bus.freeze);
        end
    endtask

    task automatic test_score();
        cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.score_ones !== 4'd1 || bus.hit !== 1'b0 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL first_pipe ones=%0d hit=%b run=%b expected ones=1 hit=0 run=1",
                     bus.score_ones, bus.hit, bus.running);
        end
        for (int i = 0; i < 9; i++) begin
            cycle(8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
            cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        end
        vectors++;
        if (bus.score_tens !== 4'd1 || bus.score_ones !== 4'd0) begin
            errors++;
            $display("FAIL bcd_carry got %0d%0d expected 10", bus.score_tens, bus.score_ones);
        end
        // Shift strobe with an empty column is not a cleared pipe.
        cycle(8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({bus.score_tens, bus.score_ones} !== 8'h10) begin
            errors++;
            $display("FAIL empty_col_shift got %0d%0d expected 10", bus.score_tens, bus.score_ones);
        end
    endtask

    task automatic test_crash_overlap();
        cycle(8'h01, 8'h03, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.game_over !== 1'b1 || bus.hit !== 1'b1 || bus.freeze !== 1'b1 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL crash_edge over=%b hit=%b frz=%b run=%b expected 1 1 1 0",
                     bus.game_over, bus.hit, bus.freeze, bus.running);
        end
        cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.hit !== 1'b0 || bus.game_over !== 1'b1) begin
            errors++;
            $display("FAIL hit_pulse hit=%b over=%b expected hit=0 over=1", bus.hit, bus.game_over);
        end
        cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({bus.score_tens, bus.score_ones} !== 8'h10) begin
            errors++;
            $display("FAIL over_frozen got %0d%0d expected 10", bus.score_tens, bus.score_ones);
        end
    endtask

    task automatic test_fall();
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);   // OVER -> IDLE
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);   // IDLE -> PLAY
        cycle(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.game_over !== 1'b1 || bus.hit !== 1'b1) begin
            errors++;
            $display("FAIL fall_off over=%b hit=%b expected 1 1", bus.game_over, bus.hit);
        end
    endtask

    task automatic test_crash_and_shift();
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        cycle(8'h08, 8'hFF, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.game_over !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h05) begin
            errors++;
            $display("FAIL crash_wins over=%b score=%0d%0d expected over=1 score=05",
                     bus.game_over, bus.score_tens, bus.score_ones);
        end
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.freeze !== 1'b1 || bus.game_over !== 1'b0 || {bus.score_tens, bus.score_ones} !== 8'h05) begin
            errors++;
            $display("FAIL idle_keeps frz=%b over=%b score=%0d%0d expected 1 0 05",
                     bus.freeze, bus.game_over, bus.score_tens, bus.score_ones);
        end
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.running !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h00) begin
            errors++;
            $display("FAIL replay_clear run=%b score=%0d%0d expected 1 00",
                     bus.running, bus.score_tens, bus.score_ones);
        end
        // start inside PLAY must not disturb anything.
        cycle(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.running !== 1'b1) begin
            errors++;
            $display("FAIL start_in_play run=%b expected 1", bus.running);
        end
    endtask

    task automatic test_saturate_and_reset();
        for (int i = 0; i < 105; i++) cycle(8'h10, 8'hE7, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({bus.score_tens, bus.score_ones} !== 8'h99 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL saturate score=%0d%0d run=%b expected 99 run=1",
                     bus.score_tens, bus.score_ones, bus.running);
        end
        cycle(8'h10, 8'h10, 1'b1, 1'b1, 1'b1);
        vectors++;
        if ({bus.score_tens, bus.score_ones} !== 8'h00 || bus.freeze !== 1'b1 ||
            bus.running !== 1'b0 || bus.game_over !== 1'b0 || bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL mid_play_reset score=%0d%0d frz=%b run=%b over=%b hit=%b expected 00 1 0 0 0",
                     bus.score_tens, bus.score_ones, bus.freeze, bus.running, bus.game_over, bus.hit);
        end
    endtask

    task automatic test_random();
        logic [7:0] pos, pc;
        logic       sh, st;
        int         r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0)       pos = 8'h00;
            else if (r >= 9)  pos = 8'($urandom);
            else              pos = 8'(1) << (r - 1);
            pc = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            sh = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 7) == 0);
            cycle(pos, pc, sh, st, ($urandom_range(0, 199) == 0));
            vectors++;
            if (bus.running !== (m_state == 1) || bus.freeze !== (m_state != 1) ||
                bus.game_over !== (m_state == 2) || bus.hit !== m_hit) begin
                errors++;
                $display("FAIL rand_flags step=%0d run=%b frz=%b over=%b hit=%b model_state=%0d model_hit=%b",
                         i, bus.running, bus.freeze, bus.game_over, bus.hit, m_state, m_hit);
            end
            vectors++;
            if (bus.score_tens !== 4'(m_score / 10) || bus.score_ones !== 4'(m_score % 10)) begin
                errors++;
                $display("FAIL rand_score step=%0d got %0d%0d expected %0d", i,
                         bus.score_tens, bus.score_ones, m_score);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        m_state = 0;
        m_score = 0;
        m_hit   = 0;
        reset          = 1'b1;
        bus.position   = 8'h10;
        bus.pipe_col   = 8'h00;
        bus.pipe_shift = 1'b0;
        bus.start      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_score();
        test_crash_overlap();
        test_fall();
        test_crash_and_shift();
        test_saturate_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
